// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants, clear-FSM encoding and width helper for the SDP BRAM
package bram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int byte_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// rtl/bram_sdp_core.sv - bare inferable simple-dual-port memory array
// Byte-enable write, registered read; the read register returns pre-write data on address collision.
module bram_sdp_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NUM_BYTES-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata_q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/bram_sdp_pipe.sv
// rtl/bram_sdp_pipe.sv - SDP BRAM with power-up clear, RDW bypass, optional output stage
// Wraps bram_sdp_core with the clear FSM, write-port mux and rd_valid pipeline.
module bram_sdp_pipe
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          we,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          rd_valid,
  output logic                          busy
);

  localparam int NB = byte_count(DATA_WIDTH);
  localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
    end
  end

  always_comb begin
    clr_wr = (state_q == ST_CLEAR) && !rst;
    busy   = rst ? (CLEAR_ON_RESET != 0) : (state_q == ST_CLEAR);
  end

  // rst also gates user access so memory is untouched while reset is held
  logic wr_acc, rd_acc, byp_hit;
  assign wr_acc  = cs && we && !busy && !rst;
  assign rd_acc  = cs && re && !busy && !rst;
  assign byp_hit = (RDW_MODE == RDW_NEW) && wr_acc && rd_acc && (waddr == raddr);

  logic                  core_we;
  logic [NB-1:0]         core_be;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0] core_din;
  logic [DATA_WIDTH-1:0] core_rdata;

  always_comb begin
    core_we    = clr_wr | wr_acc;
    core_be    = clr_wr ? {NB{1'b1}} : be;
    core_waddr = clr_wr ? clr_cnt_q : waddr;
    core_din   = clr_wr ? '0 : din;
  end

  bram_sdp_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_BYTES (NB)
  ) u_core (
    .clk    (clk),
    .we     (core_we),
    .be     (core_be),
    .waddr  (core_waddr),
    .din    (core_din),
    .re     (rd_acc),
    .raddr  (raddr),
    .rdata_q(core_rdata)
  );

  // The array's read register has no reset, so zero_q masks it to 0 until the first read after rst
  logic                  rv1_q, rv1_d;
  logic                  zero_q, zero_d;
  logic [NB-1:0]         byp_be_q, byp_be_d;
  logic [DATA_WIDTH-1:0] byp_din_q, byp_din_d;
  logic [DATA_WIDTH-1:0] read1;

  always_comb begin
    rv1_d     = rd_acc;
    zero_d    = rd_acc ? 1'b0 : zero_q;
    byp_be_d  = rd_acc ? (byp_hit ? be : '0) : byp_be_q;
    byp_din_d = rd_acc ? din : byp_din_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv1_q     <= 1'b0;
      zero_q    <= 1'b1;
      byp_be_q  <= '0;
      byp_din_q <= '0;
    end else begin
      rv1_q     <= rv1_d;
      zero_q    <= zero_d;
      byp_be_q  <= byp_be_d;
      byp_din_q <= byp_din_d;
    end
  end

  always_comb begin
    read1 = core_rdata;
    for (int i = 0; i < NB; i++) begin
      if (byp_be_q[i]) read1[8*i +: 8] = byp_din_q[8*i +: 8];
    end
    if (zero_q) read1 = '0;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout2_q, dout2_d;
    logic                  rv2_q, rv2_d;

    always_comb begin
      rv2_d   = rv1_q;
      dout2_d = rv1_q ? read1 : dout2_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rv2_q   <= 1'b0;
        dout2_q <= '0;
      end else begin
        rv2_q   <= rv2_d;
        dout2_q <= dout2_d;
      end
    end

    assign dout     = dout2_q;
    assign rd_valid = rv2_q;
  end else begin : g_no_out_reg
    assign dout     = read1;
    assign rd_valid = rv1_q;
  end

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// tb/tb_bram_sdp_pipe.sv - self-checking bench for bram_sdp_pipe (two configurations)
module tb_bram_sdp_pipe;

  logic        clk = 1'b0;
  logic        rst, cs, we, re;
  logic [3:0]  be, waddr, raddr;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic        rv0, rv1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: 1-cycle latency, old-data RDW; dut1: 2-cycle latency, new-data RDW
  bram_sdp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout0), .rd_valid(rv0), .busy(busy0));

  bram_sdp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout1), .rd_valid(rv1), .busy(busy1));

  // reference model
  logic [31:0] mem_m [16];
  int          busy_left = 0;
  logic        e0_v = 1'b0, e1_v = 1'b0, p1_v = 1'b0;
  logic [31:0] e0_d = '0, e1_d = '0, p1_w = '0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic c, input logic w, input logic [3:0] b, input logic [3:0] wa,
                     input logic [31:0] d, input logic r, input logic [3:0] ra);
    cs = c; we = w; be = b; waddr = wa; din = d; re = r; raddr = ra;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic step();
    logic        bz, rd, wr;
    logic [31:0] old_w, new_w;
    bz    = (busy_left > 0);
    rd    = cs && re && !bz;
    wr    = cs && we && !bz;
    old_w = mem_m[raddr];
    new_w = (wr && waddr == raddr) ? merge(old_w, din, be) : old_w;
    @(posedge clk);
    if (rst) begin
      busy_left = 16;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      e0_v = 1'b0; e0_d = '0;
      e1_v = 1'b0; e1_d = '0;
      p1_v = 1'b0;
    end else begin
      e1_v = p1_v;
      if (p1_v) e1_d = p1_w;
      p1_v = rd;
      if (rd) p1_w = new_w;
      e0_v = rd;
      if (rd) e0_d = old_w;
      if (wr) mem_m[waddr] = merge(mem_m[waddr], din, be);
      if (bz) busy_left--;
    end
    #1;
    chk("busy0", busy0, rst || busy_left > 0);
    chk("busy1", busy1, rst || busy_left > 0);
    chk("rv0", rv0, e0_v);
    chk("dout0", dout0, e0_d);
    chk("rv1", rv1, e1_v);
    chk("dout1", dout1, e1_d);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      if (n == 5) drv(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b1, 4'd3);
      else idle();
      step();
      n++;
    end
    chk(tag, n, 16);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a <= 16; a++) begin
      if (a < 16) drv(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a[3:0]);
      else idle();
      step();
      if (a >= 1) chk(tag, dout0, 32'h0);
    end
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    wait_clear("busy_len");
    read_all_zero("clr_rd");

    // byte enables
    drv(1'b1, 1'b1, 4'b1111, 4'd5, 32'h11223344, 1'b0, 4'd0); step();
    drv(1'b1, 1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0); step();
    drv(1'b1, 1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd5); step();
    chk("be_dout0", dout0, 32'h11BB33DD);
    chk("be_rv0", rv0, 1'b1);
    idle(); step();
    chk("be_rv0_off", rv0, 1'b0);
    chk("be_dout1", dout1, 32'h11BB33DD);
    idle(); step();

    // latency and throughput
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 4'hF, i[3:0], 32'hA0 + i, 1'b0, 4'd0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
      else idle();
      step();
      if (i >= 1 && i <= 3) begin
        chk("lat_dout1", dout1, 32'hA0 + i - 1);
        chk("lat_rv1", rv1, 1'b1);
      end
      if (i == 4) chk("lat_rv1_off", rv1, 1'b0);
    end

    // read-during-write
    drv(1'b1, 1'b1, 4'hF, 4'd7, 32'h01010101, 1'b0, 4'd0); step();
    drv(1'b1, 1'b1, 4'b0011, 4'd7, 32'hFFFFFFFF, 1'b1, 4'd7); step();
    chk("rdw_old", dout0, 32'h01010101);
    idle(); step();
    chk("rdw_new", dout1, 32'h0101FFFF);
    drv(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7); step();
    chk("rdw_after0", dout0, 32'h0101FFFF);
    idle(); step();
    chk("rdw_after1", dout1, 32'h0101FFFF);

    // chip-select gating
    drv(1'b0, 1'b1, 4'hF, 4'd2, 32'h55, 1'b1, 4'd2); step();
    chk("cs_rv0", rv0, 1'b0);
    idle(); step();
    chk("cs_rv1", rv1, 1'b0);
    drv(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2); step();
    chk("cs_mem", dout0, 32'hA2);
    idle(); step();

    // reset in the middle of the clear
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1; step();
    chk("mid_dout0", dout0, 32'h0);
    chk("mid_rv0", rv0, 1'b0);
    chk("mid_dout1", dout1, 32'h0);
    rst = 1'b0;
    wait_clear("mid_busy_len");
    read_all_zero("mid_clr_rd");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, 4'($urandom),
          4'($urandom), $urandom, $urandom_range(0, 2) != 0, 4'($urandom));
      step();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 20; i++) step();
    for (int a = 0; a < 16; a++) begin
      drv(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a[3:0]);
      step();
    end
    idle(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_sdp_pipe.md
Name: bram_sdp_pipe

Overview:
Parametrised simple-dual-port block RAM and the successor to the single-port asynchronous-read RAM. It has one write port and one independent read port on a single clock. Reads are registered with 1- or 2-cycle latency and a valid strobe. Writes support byte enables, read-during-write behaviour is selectable, and an optional power-up clear sequencer zeroes every location after reset. It sits behind the packet buffers and register files wherever a synchronous, inferable BRAM with known initial contents is needed.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words, so every address is backed by storage.
OUT_REG, 0, 0 = 1-cycle read latency; 1 = an extra output register, giving 2-cycle latency.
RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = read returns new (byte-merged) data.
CLEAR_ON_RESET, 1, 1 = zero all DEPTH words after reset; 0 = no clear, contents undefined.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cs  input  1  chip select; gates both ports.
we  input  1  write strobe, qualified by cs.
be  input  DATA_WIDTH/8  byte enables; bit i controls din[8i+7:8i].
waddr  input  ADDR_WIDTH  write address.
din  input  DATA_WIDTH  write data.
re  input  1  read strobe, qualified by cs.
raddr  input  ADDR_WIDTH  read address.
dout  output  DATA_WIDTH  read data; valid only while rd_valid = 1.
rd_valid  output  1  high for exactly one cycle per accepted read, aligned with dout.
busy  output  1  high while the clear sequencer runs; user accesses are ignored while busy.

Behaviour:
- Reset: while rst = 1, dout = 0, rd_valid = 0, and the pipeline is flushed. busy = 1 if CLEAR_ON_RESET = 1, else 0. Memory contents are not touched during rst.
- FSM states are IDLE and CLEAR.
  - On rst with CLEAR_ON_RESET = 1, the FSM enters CLEAR with clr_cnt = 0. Otherwise it enters IDLE.
  - In CLEAR, each cycle writes 0 to mem[clr_cnt], then clr_cnt increments.
  - When clr_cnt = DEPTH-1 is written, the FSM goes to IDLE and busy drops the next cycle.
  - Busy therefore lasts exactly DEPTH cycles after rst deasserts.
- rst asserted mid-clear restarts the clear from address 0.
- While busy = 1, user writes are dropped and user reads are not accepted (no rd_valid).
- Write accepted when cs & we & !busy. Only bytes with be[i] = 1 are updated; be = 0 leaves the word unchanged.
- Read accepted when cs & re & !busy.
  - OUT_REG = 0: dout and rd_valid are updated at the edge that samples the read (latency 1).
  - OUT_REG = 1: one further register stage (latency 2).
- Back-to-back reads every cycle give full throughput: one word per cycle.
- When no read is accepted, rd_valid = 0 and dout holds its last value.
- Same address read and write in one cycle: RDW_MODE = 0 returns the pre-write word. RDW_MODE = 1 returns the pre-write word with enabled bytes replaced by din.
- Different addresses in one cycle: the two ports are fully independent.
- Addresses use the full ADDR_WIDTH range; there is no wrap or aliasing logic.
- Read-modify-write hazards are the user's responsibility beyond the RDW rule above.

Decomposition:
- Shared package bram_pkg holds:
  - RDW_OLD = 0 and RDW_NEW = 1 constants.
  - The clear-FSM state encoding (ST_IDLE, ST_CLEAR).
  - A function computing byte count from DATA_WIDTH.
- One sub-module, bram_sdp_core: the bare inferable memory array with byte-enable write and registered read, and no control logic.
- The top level holds the clear FSM, write-port muxing (clear vs user), RDW bypass, the optional output stage, and the rd_valid pipeline.

Test Plan:
- Reset clear, defaults with ADDR_WIDTH = 4: pulse rst for 1 cycle -> busy high for exactly 16 cycles. A write of 0xDEADBEEF to addr 3 during busy is ignored. After busy drops, reading all 16 addresses returns 0.
- Byte enables: write 0x11223344 to addr 5 with be = 4'b1111, then 0xAABBCCDD with be = 4'b0101 -> read addr 5 returns 0x11BB33DD one cycle later with rd_valid = 1 for one cycle.
- Latency and throughput with OUT_REG = 1: reads of addrs 0,1,2 on consecutive cycles after writing 0xA0, 0xA1, 0xA2 -> dout = 0xA0, 0xA1, 0xA2 on cycles +2, +3, +4 with rd_valid high for those 3 cycles only.
- Read-during-write: mem[7] = 0x01010101; same cycle write 0xFFFFFFFF be = 4'b0011 and read addr 7 -> RDW_MODE = 0 returns 0x01010101; RDW_MODE = 1 returns 0x0101FFFF. A subsequent read returns 0x0101FFFF in both modes.
- cs gating: we = 1, re = 1, cs = 0 with din = 0x55 at addr 2 -> no memory change and rd_valid stays 0.
- Reset mid-clear: assert rst at clear cycle 9 -> dout = 0 and rd_valid = 0 during rst. busy then stays high a full 16 cycles after rst release, and all locations read 0.
